// File: rtl/varredura_pkg.sv
// Shared state encoding and sizes for the column-letter scanner.
// Build macro VARREDURA_BLANK_EN adds the BLANK state between columns.
package varredura_pkg;

   localparam int COL_W   = 3;
   localparam int MAX_COL = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1
`ifdef VARREDURA_BLANK_EN
      ,BLANK = 2'd2
`endif
   } state_t;

endpackage

// File: rtl/divisor_tick.sv
// Column-hold prescaler: counts enabled cycles 0..DIV_MAX and flags the terminal one.
// clr holds the count at zero so each column starts a fresh hold period.
module divisor_tick #(
   parameter int DIV_MAX = 49999
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
   localparam logic [CW-1:0] TERM = CW'(DIV_MAX);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (enable)
         cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tick = enable && !clr && (cnt_q == TERM);

endmodule

// File: rtl/varredura_coluna_letra.sv
// Column scanner for a letter display: one-hot column drive plus 3-bit column code.
// Build macro VARREDURA_BLANK_EN inserts BLANK_CYC dark cycles between columns.
module varredura_coluna_letra
   import varredura_pkg::*;
#(
   parameter int DIV_MAX   = 49999,
   parameter int NUM_COL   = 5,
   parameter int BLANK_CYC = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               start,
   input  logic               continuo,
   input  logic               stop,
   output logic               A,
   output logic               B,
   output logic               C,
   output logic [NUM_COL-1:0] col_sel,
   output logic               busy,
   output logic               frame_done,
   output logic [1:0]         dbg_state_o
);

   if (NUM_COL < 2 || NUM_COL > MAX_COL || BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_param_check
      $error("varredura_coluna_letra: NUM_COL or BLANK_CYC out of range");
   end

   localparam logic [NUM_COL-1:0] SEL0 = {{(NUM_COL-1){1'b0}}, 1'b1};
   localparam logic [COL_W-1:0]   LAST_COL = COL_W'(NUM_COL - 1);

   state_t             state_q;
   logic [COL_W-1:0]   col_q;
   logic [NUM_COL-1:0] col_sel_q;
   logic               busy_q;
   logic               done_q;
   logic               tick;
   logic               last_col;
   logic [COL_W-1:0]   col_d;

`ifdef VARREDURA_BLANK_EN
   localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);
   logic [7:0]         blank_q;
   logic [NUM_COL-1:0] cur_sel;
   assign cur_sel = SEL0 << col_q;
`else
   logic [NUM_COL-1:0] next_sel;
   assign next_sel = SEL0 << col_d;
`endif

   // The last column wraps to 0 so code NUM_COL never appears.
   assign last_col = (col_q == LAST_COL);
   assign col_d    = last_col ? '0 : col_q + COL_W'(1);

   divisor_tick #(.DIV_MAX(DIV_MAX)) u_div (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clr    (state_q != SCAN),
      .tick   (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         col_q     <= '0;
         col_sel_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef VARREDURA_BLANK_EN
         blank_q   <= '0;
`endif
      end else if (stop) begin
         // Abort wins over start and over the freeze; an aborted frame never reports done.
         state_q   <= IDLE;
         col_q     <= '0;
         col_sel_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef VARREDURA_BLANK_EN
         blank_q   <= '0;
`endif
      end else if (!enable) begin
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= SCAN;
                  col_q     <= '0;
                  col_sel_q <= SEL0;
                  busy_q    <= 1'b1;
               end
            end
            SCAN: begin
               if (tick) begin
                  col_q <= col_d;
                  if (last_col)
                     done_q <= 1'b1;
                  if (last_col && !continuo) begin
                     state_q   <= IDLE;
                     col_sel_q <= '0;
                     busy_q    <= 1'b0;
                  end else begin
`ifdef VARREDURA_BLANK_EN
                     state_q   <= BLANK;
                     col_sel_q <= '0;
                     blank_q   <= '0;
`else
                     col_sel_q <= next_sel;
`endif
                  end
               end
            end
`ifdef VARREDURA_BLANK_EN
            BLANK: begin
               if (blank_q == BLANK_LAST) begin
                  state_q   <= SCAN;
                  col_sel_q <= cur_sel;
                  blank_q   <= '0;
               end else begin
                  blank_q <= blank_q + 8'd1;
               end
            end
`endif
            default: begin
               state_q   <= IDLE;
               col_sel_q <= '0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign {A, B, C}   = col_q;
   assign col_sel     = col_sel_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_varredura_coluna_letra.sv
// Directed bench for varredura_coluna_letra with DIV_MAX=3, NUM_COL=5, BLANK_CYC=1.
// Expected timing follows VARREDURA_BLANK_EN (one blank cycle per gap when defined).
module tb_varredura_coluna_letra;

   localparam int DIVC = 4;
   localparam int NCOL = 5;
`ifdef VARREDURA_BLANK_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 0;
`endif
   localparam int FRAME_LEN = NCOL * DIVC + (NCOL - 1) * GAP;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       start = 1'b0;
   logic       continuo = 1'b0;
   logic       stop = 1'b0;
   logic       A, B, C;
   logic [4:0] col_sel;
   logic       busy, frame_done;
   logic [1:0] dbg_state;
   logic [9:0] obs_v;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   varredura_coluna_letra #(
      .DIV_MAX   (3),
      .NUM_COL   (5),
      .BLANK_CYC (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .start       (start),
      .continuo    (continuo),
      .stop        (stop),
      .A           (A),
      .B           (B),
      .C           (C),
      .col_sel     (col_sel),
      .busy        (busy),
      .frame_done  (frame_done),
      .dbg_state_o (dbg_state)
   );

   // {busy, frame_done, code[2:0], col_sel[4:0]}
   assign obs_v = {busy, frame_done, A, B, C, col_sel};

   // Expected outputs idx cycles after the start edge; idx == FRAME_LEN is the done cycle.
   function automatic logic [9:0] exp_vec(input int idx);
      int r;
      r = idx;
      for (int c = 0; c < NCOL; c++) begin
         if (r < DIVC) return {1'b1, 1'b0, 3'(c), 5'(1 << c)};
         r = r - DIVC;
         if (c < NCOL - 1) begin
            if (r < GAP) return {1'b1, 1'b0, 3'(c + 1), 5'b00000};
            r = r - GAP;
         end
      end
      return {1'b0, 1'b1, 3'b000, 5'b00000};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b0;
      step();
      step();
      checks++;
      if (obs_v !== 10'b0 || dbg_state !== 2'd0) begin
         $display("FAIL reset_state got=%b st=%0d exp=%b st=0", obs_v, dbg_state, 10'b0);
         errors++;
      end
      reset = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (obs_v !== 10'b0) begin
         $display("FAIL start_disabled got=%b exp=%b", obs_v, 10'b0);
         errors++;
      end
      enable = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0) begin
         $display("FAIL idle_hold busy=%b exp=0", busy);
         errors++;
      end
   endtask

   task automatic test_single_frame();
      logic [9:0] exp_v;
      continuo = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i <= FRAME_LEN; i++) begin
         exp_v = exp_vec(i);
         checks++;
         if (obs_v !== exp_v) begin
            $display("FAIL single_frame cyc=%0d got=%b exp=%b", i, obs_v, exp_v);
            errors++;
         end
         start = (i == 9);
         step();
      end
      start = 1'b0;
      checks++;
      if (obs_v !== 10'b0 || dbg_state !== 2'd0) begin
         $display("FAIL single_frame_after got=%b st=%0d exp=%b st=0", obs_v, dbg_state, 10'b0);
         errors++;
      end
   endtask

   task automatic test_continuous();
      int n_done;
      int last_t;
      int exp_t;
      n_done = 0;
      last_t = 0;
      continuo = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int t = 0; t < 200 && n_done < 3; t++) begin
         if (t == FRAME_LEN + GAP) begin
            checks++;
            if (col_sel !== 5'b00001 || {A, B, C} !== 3'b000) begin
               $display("FAIL cont_restart col_sel=%b code=%b exp=00001 000", col_sel, {A, B, C});
               errors++;
            end
         end
         if (frame_done === 1'b1) begin
            exp_t = (n_done == 0) ? FRAME_LEN : last_t + FRAME_LEN + GAP;
            checks++;
            if (t !== exp_t) begin
               $display("FAIL cont_done_time n=%0d got=%0d exp=%0d", n_done, t, exp_t);
               errors++;
            end
            checks++;
            if ({A, B, C} !== 3'b000 || busy !== 1'b1) begin
               $display("FAIL cont_wrap code=%b busy=%b exp=000 1", {A, B, C}, busy);
               errors++;
            end
            last_t = t;
            n_done++;
         end
         step();
      end
      checks++;
      if (n_done !== 3) begin
         $display("FAIL cont_count got=%0d exp=3", n_done);
         errors++;
      end
      continuo = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         $display("FAIL cont_stop busy=%b exp=0", busy);
         errors++;
      end
   endtask

   task automatic test_stop();
      int n_act;
      n_act = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 2 * (DIVC + GAP) + 1; i++) step();
      checks++;
      if (col_sel !== 5'b00100 || {A, B, C} !== 3'b010) begin
         $display("FAIL stop_pre col_sel=%b code=%b exp=00100 010", col_sel, {A, B, C});
         errors++;
      end
      stop = 1'b1;
      start = 1'b1;
      step();
      stop = 1'b0;
      start = 1'b0;
      checks++;
      if (obs_v !== 10'b0 || dbg_state !== 2'd0) begin
         $display("FAIL stop_idle got=%b st=%0d exp=%b st=0", obs_v, dbg_state, 10'b0);
         errors++;
      end
      for (int i = 0; i < FRAME_LEN + 4; i++) begin
         if (frame_done !== 1'b0 || busy !== 1'b0) n_act++;
         step();
      end
      checks++;
      if (n_act !== 0) begin
         $display("FAIL stop_quiet active_cycles=%0d exp=0", n_act);
         errors++;
      end
   endtask

   task automatic test_freeze();
      logic [9:0] exp_v;
      int bad;
      bad = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i <= FRAME_LEN; i++) begin
         exp_v = exp_vec(i);
         checks++;
         if (obs_v !== exp_v) begin
            $display("FAIL freeze_frame cyc=%0d got=%b exp=%b", i, obs_v, exp_v);
            errors++;
         end
         if (i == DIVC + GAP + 1) begin
            enable = 1'b0;
            for (int k = 0; k < 10; k++) begin
               step();
               if (obs_v !== {1'b1, 1'b0, 3'b001, 5'b00010}) bad++;
            end
            checks++;
            if (bad !== 0) begin
               $display("FAIL freeze_hold bad_cycles=%0d exp=0 last=%b", bad, obs_v);
               errors++;
            end
            enable = 1'b1;
         end
         if (i < FRAME_LEN) step();
      end
      enable = 1'b0;
      step();
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL freeze_done_refire done=%b busy=%b exp=0 0", frame_done, busy);
         errors++;
      end
      enable = 1'b1;
      step();
   endtask

   task automatic test_async_reset();
      logic [9:0] exp_v;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (DIVC) step();
      exp_v = exp_vec(DIVC);
      checks++;
      if (obs_v !== exp_v) begin
         $display("FAIL areset_pre got=%b exp=%b", obs_v, exp_v);
         errors++;
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (obs_v !== 10'b0 || dbg_state !== 2'd0) begin
         $display("FAIL areset_async got=%b st=%0d exp=%b st=0", obs_v, dbg_state, 10'b0);
         errors++;
      end
      #1 reset = 1'b0;
      step();
      step();
      checks++;
      if (obs_v !== 10'b0) begin
         $display("FAIL areset_idle got=%b exp=%b", obs_v, 10'b0);
         errors++;
      end
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i <= FRAME_LEN; i++) begin
         exp_v = exp_vec(i);
         checks++;
         if (obs_v !== exp_v) begin
            $display("FAIL areset_frame cyc=%0d got=%b exp=%b", i, obs_v, exp_v);
            errors++;
         end
         if (i < FRAME_LEN) step();
      end
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_continuous();
      test_stop();
      test_freeze();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
